// File: rtl/gerador_pwm_multicanal.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gerador_pwm_multicanal
// Purpose  : CANAIS-channel PWM generator with debounced +/-/channel buttons
//            and a two-digit 7-segment readout of the selected channel's duty.
// Revision : 1.0 - initial release
// ============================================================================
module gerador_pwm_multicanal #(
    parameter int CANAIS   = 4,
    parameter int DIV      = 500,
    parameter int DEBOUNCE = 50000,
    parameter int WRAP     = 0,
    localparam int SEL_W   = (CANAIS > 1) ? $clog2(CANAIS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_mais,
    input  logic              btn_menos,
    input  logic              btn_canal,
    output logic [CANAIS-1:0] pwm,
    output logic [SEL_W-1:0]  canal_sel,
    output logic [6:0]        display_ls,
    output logic [6:0]        display_ms,
    output logic              led
);

    localparam int         DB_W  = $clog2(DEBOUNCE + 1);
    localparam int         PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [6:0] C_MAX = 7'd99;

    logic [2:0]        btn_raw;
    logic [2:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]        stable_q, stable_d, press_q, press_d;
    logic [DB_W-1:0]   deb_cnt_q [3];
    logic [DB_W-1:0]   deb_cnt_d [3];
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [6:0]        duty_q [CANAIS];
    logic [6:0]        duty_d [CANAIS];
    logic [6:0]        shadow_q [CANAIS];
    logic [6:0]        shadow_d [CANAIS];
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [6:0]        phase_q, phase_d;
    logic [CANAIS-1:0] pwm_q, pwm_d;
    logic              led_q, led_d;
    logic [6:0]        disp_ls_q, disp_ls_d, disp_ms_q, disp_ms_d;
    logic              tick;
    logic [6:0]        duty_cur, duty_new;
    logic [3:0]        tens, units;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign btn_raw = {btn_canal, btn_menos, btn_mais};

    // Bit 0 = mais, bit 1 = menos, bit 2 = canal; press pulses only on accepted rises.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press_d  = 3'b000;
        for (int b = 0; b < 3; b++) begin
            deb_cnt_d[b] = '0;
            if (sync2_q[b] != stable_q[b]) begin
                if (deb_cnt_q[b] == DB_W'(DEBOUNCE - 1)) begin
                    stable_d[b] = sync2_q[b];
                    press_d[b]  = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_d = sel_q;
        for (int i = 0; i < CANAIS; i++) begin
            duty_d[i] = duty_q[i];
        end
        duty_cur = duty_q[sel_q];
        duty_new = duty_cur;
        if (press_q[0] && !press_q[1]) begin
            duty_new = (duty_cur == C_MAX) ? ((WRAP != 0) ? 7'd0 : C_MAX) : duty_cur + 7'd1;
        end else if (press_q[1] && !press_q[0]) begin
            duty_new = (duty_cur == 7'd0) ? ((WRAP != 0) ? C_MAX : 7'd0) : duty_cur - 7'd1;
        end
        // Duty edit uses the channel selected before a coincident canal press.
        duty_d[sel_q] = duty_new;
        if (press_q[2]) begin
            sel_d = (sel_q == SEL_W'(CANAIS - 1)) ? '0 : sel_q + 1'b1;
        end

        tick    = (presc_q == PS_W'(DIV - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
        phase_d = phase_q;
        if (tick) begin
            phase_d = (phase_q == C_MAX) ? 7'd0 : phase_q + 7'd1;
        end
        for (int i = 0; i < CANAIS; i++) begin
            shadow_d[i] = (tick && (phase_q == C_MAX)) ? duty_q[i] : shadow_q[i];
            pwm_d[i]    = (phase_q < shadow_q[i]);
        end
        led_d = pwm_d[sel_d];

        tens = 4'd0;
        for (int t = 1; t < 10; t++) begin
            if (duty_cur >= 7'(t * 10)) begin
                tens = 4'(t);
            end
        end
        units     = 4'(duty_cur - 7'(tens) * 7'd10);
        disp_ls_d = seg7(units);
        disp_ms_d = seg7(tens);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            for (int b = 0; b < 3; b++) begin
                deb_cnt_q[b] <= '0;
            end
            sel_q     <= '0;
            for (int i = 0; i < CANAIS; i++) begin
                duty_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            presc_q   <= '0;
            phase_q   <= '0;
            pwm_q     <= '0;
            led_q     <= 1'b0;
            disp_ls_q <= 7'h40;
            disp_ms_q <= 7'h40;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            for (int b = 0; b < 3; b++) begin
                deb_cnt_q[b] <= deb_cnt_d[b];
            end
            sel_q     <= sel_d;
            for (int i = 0; i < CANAIS; i++) begin
                duty_q[i]   <= duty_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            pwm_q     <= pwm_d;
            led_q     <= led_d;
            disp_ls_q <= disp_ls_d;
            disp_ms_q <= disp_ms_d;
        end
    end

    assign pwm        = pwm_q;
    assign canal_sel  = sel_q;
    assign display_ls = disp_ls_q;
    assign display_ms = disp_ms_q;
    assign led        = led_q;

endmodule
`default_nettype wire

// File: tb/tb_gerador_pwm_multicanal.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gerador_pwm_multicanal
// Purpose  : Self-checking bench; saturating (WRAP=0) and wrapping (WRAP=1)
//            instances driven by the same buttons.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gerador_pwm_multicanal;

    typedef struct { logic [2:0] btn; int sel; int d0; int d1; } vec_t;
    typedef struct { int sel; int d0; int d1; } exp_t;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       btn_mais  = 1'b0;
    logic       btn_menos = 1'b0;
    logic       btn_canal = 1'b0;
    logic [3:0] pwm0, pwm1;
    logic [1:0] sel0, sel1;
    logic [6:0] ls0, ms0, ls1, ms1;
    logic       led0, led1;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    vec_t tbl[20];

    always #5 clock = ~clock;

    gerador_pwm_multicanal #(.CANAIS(4), .DIV(2), .DEBOUNCE(4), .WRAP(0)) u_w0 (
        .clock(clock), .reset(reset), .btn_mais(btn_mais), .btn_menos(btn_menos),
        .btn_canal(btn_canal), .pwm(pwm0), .canal_sel(sel0), .display_ls(ls0),
        .display_ms(ms0), .led(led0));

    gerador_pwm_multicanal #(.CANAIS(4), .DIV(2), .DEBOUNCE(4), .WRAP(1)) u_w1 (
        .clock(clock), .reset(reset), .btn_mais(btn_mais), .btn_menos(btn_menos),
        .btn_canal(btn_canal), .pwm(pwm1), .canal_sel(sel1), .display_ls(ls1),
        .display_ms(ms1), .led(led1));

    function automatic logic [6:0] seg(input int d);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] b);
        @(negedge clock);
        {btn_canal, btn_menos, btn_mais} = b;
        repeat (10) @(negedge clock);
        {btn_canal, btn_menos, btn_mais} = 3'b000;
        repeat (12) @(negedge clock);
    endtask

    task automatic apply(input logic [2:0] b, input int s, input int d0, input int d1);
        exp_t e;
        sb.push_back('{sel: s, d0: d0, d1: d1});
        press(b);
        e = sb.pop_front();
        check("canal_sel_w0", 32'(sel0), e.sel);
        check("canal_sel_w1", 32'(sel1), e.sel);
        check("display_ls_w0", 32'(ls0), 32'(seg(e.d0 % 10)));
        check("display_ms_w0", 32'(ms0), 32'(seg(e.d0 / 10)));
        check("display_ls_w1", 32'(ls1), 32'(seg(e.d1 % 10)));
        check("display_ms_w1", 32'(ms1), 32'(seg(e.d1 / 10)));
    endtask

    // Counts consecutive samples at level lvl of one pwm bit, bounded by maxc.
    task automatic run_len(input int inst, input int ch, input logic lvl,
                           input int maxc, output int n);
        logic [3:0] v;
        n = 0;
        v = (inst == 0) ? pwm0 : pwm1;
        while ((v[ch] === lvl) && (n < maxc)) begin
            @(negedge clock);
            n++;
            v = (inst == 0) ? pwm0 : pwm1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int c0[4];
        int c1[4];
        int e0[4];
        int e1[4];
        int m0, m1;
        logic [3:0] v;

        tbl[0]  = '{3'b010, 0, 0, 0};
        tbl[1]  = '{3'b010, 0, 0, 99};
        tbl[2]  = '{3'b001, 0, 1, 0};
        tbl[3]  = '{3'b001, 0, 2, 1};
        tbl[4]  = '{3'b001, 0, 3, 2};
        tbl[5]  = '{3'b100, 1, 0, 0};
        for (int k = 6; k <= 12; k++) tbl[k] = '{3'b001, 1, k - 5, k - 5};
        tbl[13] = '{3'b011, 1, 7, 7};
        tbl[14] = '{3'b101, 2, 0, 0};
        tbl[15] = '{3'b100, 3, 0, 0};
        tbl[16] = '{3'b100, 0, 3, 2};
        tbl[17] = '{3'b100, 1, 8, 8};
        tbl[18] = '{3'b010, 1, 7, 7};
        tbl[19] = '{3'b100, 2, 0, 0};

        // Reset state
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_pwm_w0", 32'(pwm0), 0);
        check("reset_pwm_w1", 32'(pwm1), 0);
        check("reset_led_w0", 32'(led0), 0);
        check("reset_canal_sel", 32'(sel0), 0);
        check("reset_display_ls", 32'(ls0), 32'h40);
        check("reset_display_ms", 32'(ms0), 32'h40);
        reset = 1'b1;
        n = 0;
        repeat (400) begin
            @(negedge clock);
            if ((pwm0 !== 4'b0) || (pwm1 !== 4'b0) || (led0 !== 1'b0)) n++;
        end
        check("pwm_idle_after_reset", n, 0);

        // Short glitches are rejected, a held press counts once
        repeat (3) begin
            @(negedge clock);
            btn_mais = 1'b1;
            repeat (3) @(negedge clock);
            btn_mais = 1'b0;
            repeat (3) @(negedge clock);
        end
        repeat (10) @(negedge clock);
        check("glitch_display_ls_w0", 32'(ls0), 32'h40);
        check("glitch_display_ls_w1", 32'(ls1), 32'h40);
        apply(3'b001, 0, 1, 1);

        for (int i = 0; i < 20; i++) apply(tbl[i].btn, tbl[i].sel, tbl[i].d0, tbl[i].d1);

        // Channel 2 at 25 %: 50 high / 150 low cycles per 200-cycle period
        for (int k = 1; k <= 25; k++) apply(3'b001, 2, k, k);
        run_len(0, 2, 1'b1, 250, n);
        run_len(0, 2, 1'b0, 250, n);
        check("ch2_rise_seen", 32'(pwm0[2]), 1);
        run_len(0, 2, 1'b1, 400, n);
        check("ch2_high_cycles", n, 50);
        run_len(0, 2, 1'b0, 400, n);
        check("ch2_low_cycles", n, 150);

        // Channel 3 to the upper limit: saturates at 99 vs wraps to 0
        apply(3'b100, 3, 0, 0);
        for (int k = 1; k <= 100; k++) apply(3'b001, 3, (k > 99) ? 99 : k, k % 100);
        repeat (250) @(negedge clock);

        // Jump 0 -> 99 on the wrapping instance must not reach pwm before the wrap
        @(negedge clock);
        btn_menos = 1'b1;
        n = 0;
        while ((ms1 !== seg(9)) && (n < 40)) begin
            @(negedge clock);
            n++;
        end
        check("jump_display_ms_w1", 32'(ms1), 32'(seg(9)));
        check("jump_no_runt_w1", 32'(pwm1[3]), 0);
        btn_menos = 1'b0;
        run_len(1, 3, 1'b0, 300, n);
        check("ch3_rise_seen_w1", 32'(pwm1[3]), 1);
        run_len(1, 3, 1'b1, 400, n);
        check("duty99_high_cycles", n, 198);
        run_len(1, 3, 1'b0, 50, n);
        check("duty99_low_cycles", n, 2);
        check("jump_display_ls_w0", 32'(ls0), 32'(seg(8)));
        check("jump_display_ms_w0", 32'(ms0), 32'(seg(9)));

        // Steady state of every channel over one full period
        e0 = '{6, 14, 50, 196};
        e1 = '{4, 14, 50, 198};
        c0 = '{0, 0, 0, 0};
        c1 = '{0, 0, 0, 0};
        m0 = 0;
        m1 = 0;
        repeat (200) begin
            @(negedge clock);
            for (int i = 0; i < 4; i++) begin
                v = pwm0;
                if (v[i] === 1'b1) c0[i]++;
                v = pwm1;
                if (v[i] === 1'b1) c1[i]++;
            end
            if (led0 !== pwm0[3]) m0++;
            if (led1 !== pwm1[3]) m1++;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("high_cycles_w0_ch%0d", i), c0[i], e0[i]);
            check($sformatf("high_cycles_w1_ch%0d", i), c1[i], e1[i]);
        end
        check("led_follows_pwm_w0", m0, 0);
        check("led_follows_pwm_w1", m1, 0);

        // Reset mid-period clears outputs immediately
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midreset_pwm_w0", 32'(pwm0), 0);
        check("midreset_pwm_w1", 32'(pwm1), 0);
        check("midreset_led_w0", 32'(led0), 0);
        check("midreset_canal_sel", 32'(sel0), 0);
        check("midreset_display_ls", 32'(ls0), 32'h40);
        check("midreset_display_ms", 32'(ms0), 32'h40);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Reset mid-debounce: no press emerges afterwards
        repeat (2) @(negedge clock);
        btn_mais = 1'b1;
        repeat (5) @(negedge clock);
        reset    = 1'b0;
        btn_mais = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("debounce_reset_display_ls", 32'(ls0), 32'h40);
        check("debounce_reset_pwm", 32'(pwm0), 0);
        apply(3'b001, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
